// File: rtl/ff_write_arbiter.sv
// Round-robin write arbiter for a single shared enable-flop register, with
// bounded lock bursts that let one requester keep priority for a few grants.
module ff_write_arbiter #(
  parameter int unsigned PARAM_WIDTH = 8,
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned MAX_LOCK    = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_lock,
  input  logic [NUM_REQ*PARAM_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [PARAM_WIDTH-1:0]         q,
  output logic [$clog2(NUM_REQ)-1:0]     q_owner,
  output logic                           q_update,
  output logic                           lock_active
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned CntW = 8;
  localparam logic [CntW-1:0] MaxLockC = CntW'(MAX_LOCK);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(NUM_REQ - 1);

  logic [IdxW-1:0]        ptr_q;
  logic [CntW-1:0]        lcnt_q;
  logic [IdxW-1:0]        cand;
  logic [IdxW-1:0]        win;
  logic [IdxW-1:0]        win_next;
  logic                   found;
  logic                   hs;
  logic                   burst_cont;
  logic [PARAM_WIDTH-1:0] win_data;

  // Scan from the priority pointer, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IdxW'((32'(ptr_q) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && enable && found) begin
      req_ready[win] = 1'b1;
    end
  end

  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win == IdxW'(i)) begin
        win_data = req_data[i*PARAM_WIDTH +: PARAM_WIDTH];
      end
    end
  end

  assign hs         = |(req_valid & req_ready);
  assign win_next   = (win == LastIdx) ? '0 : win + IdxW'(1);
  // A burst continues only when the same owner wins again while locked.
  assign burst_cont = lock_active && (win == q_owner);

  always_ff @(posedge clk) begin
    if (rst) begin
      q           <= '0;
      q_owner     <= '0;
      q_update    <= 1'b0;
      lock_active <= 1'b0;
      ptr_q       <= '0;
      lcnt_q      <= '0;
    end else begin
      q_update <= hs;
      if (hs) begin
        q       <= win_data;
        q_owner <= win;
        if (req_lock[win] && !burst_cont) begin
          ptr_q       <= win;
          lcnt_q      <= CntW'(1);
          lock_active <= 1'b1;
        end else if (req_lock[win] && (lcnt_q < MaxLockC)) begin
          ptr_q       <= win;
          lcnt_q      <= lcnt_q + CntW'(1);
          lock_active <= 1'b1;
        end else begin
          ptr_q       <= win_next;
          lcnt_q      <= '0;
          lock_active <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/ff_write_arbiter.md
Name: ff_write_arbiter

Overview:
- Round-robin arbiter and sequencer for one shared enable-flop data register. Up to NUM_REQ requesters compete to write the register.
- The block picks one winner per cycle, drives the register's enable/data, and reports the new value, its owner and an update strobe.
- A requester may hold priority for a bounded burst using a lock input. A lock counter caps the burst to prevent starvation.
- Sits between control agents and the shared configuration/status register in the datapath.

Parameters:
- PARAM_WIDTH, 8, width of the stored register value and each requester's data.
- NUM_REQ, 4, number of requesters (2..16).
- MAX_LOCK, 4, maximum consecutive grants to one locked requester before priority is forced onward (1..255).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous active-high reset.
- enable  input  1  global arbitration enable; 0 blocks all grants.
- req_valid  input  NUM_REQ  per-requester write request.
- req_lock  input  NUM_REQ  per-requester request to keep priority after its grant.
- req_data  input  NUM_REQ*PARAM_WIDTH  packed write data; requester i occupies bits [i*PARAM_WIDTH +: PARAM_WIDTH].
- req_ready  output  NUM_REQ  one-hot grant, combinational in the current cycle.
- q  output  PARAM_WIDTH  registered shared value.
- q_owner  output  clog2(NUM_REQ)  index of the last writer.
- q_update  output  1  one-cycle pulse, high the cycle after a write.
- lock_active  output  1  high while a locked burst holds the priority pointer.

Behaviour:
- Reset (synchronous, sampled at the rising edge with rst=1) sets q=0, q_owner=0, q_update=0, lock_active=0, priority pointer ptr=0 and lock counter lcnt=0.
- While rst=1, req_ready is forced to 0.
- Grant is combinational. With enable=1, the winner is the first index i with req_valid[i]=1, scanning ptr, ptr+1, ... modulo NUM_REQ (wrap-around).
- req_ready is one-hot on the winner. It is all-zero if no valid request exists or enable=0.
- A handshake completes in any cycle where req_valid[i] and req_ready[i] are both 1. Requesters hold req_valid/req_data until ready; this block does not buffer requests.
- On the edge after a completed handshake:
  - q <= winner data, q_owner <= winner, q_update <= 1.
  - Latency is one cycle from grant to q visible.
- On an edge with no handshake: q and q_owner hold, q_update <= 0.
- Pointer and lock update, on a handshake by winner w:
  - If req_lock[w]=1 and (w != q_owner or !lock_active) → start a burst: ptr <= w, lcnt <= 1, lock_active <= 1.
  - If req_lock[w]=1, lock_active=1, w==q_owner and lcnt < MAX_LOCK → ptr <= w, lcnt <= lcnt+1, lock_active <= 1.
  - If req_lock[w]=1, lock_active=1, w==q_owner and lcnt == MAX_LOCK → cap reached: ptr <= (w+1) mod NUM_REQ, lcnt <= 0, lock_active <= 0.
  - If req_lock[w]=0 → ptr <= (w+1) mod NUM_REQ, lcnt <= 0, lock_active <= 0.
- With no handshake, ptr, lcnt and lock_active hold. A locked requester that drops req_valid keeps priority until another requester wins.
- MAX_LOCK=1: lock gives exactly one extra grant before the pointer advances (the starting grant plus one).
- enable=0 mid-burst: no grants; ptr, lcnt and lock_active are frozen and resume when enable returns.
- rst asserted mid-burst: all state is cleared; the burst is abandoned. Simultaneous rst and a valid request: reset wins, no write, q_update=0.
- A write with data equal to the current q still pulses q_update.
- The arbiter is free of bubbles: back-to-back writes are possible every cycle, and q_update stays high across consecutive cycles.

Test Plan:
- Reset: rst=1 for 2 cycles with all req_valid=1 → req_ready=0, q=0x00, q_owner=0, q_update=0; first cycle after rst drops: req_ready=0001.
- Round robin: NUM_REQ=4, all valid, data 0x11/0x22/0x33/0x44, no lock → grant order 0,1,2,3,0; q sequence 0x11,0x22,0x33,0x44,0x11, each one cycle after its grant; q_update continuously 1.
- Wrap and skip: ptr=3, req_valid=0101 → grant 0 (wraps past 3); next cycle grant 2.
- Lock cap: MAX_LOCK=4, req 1 valid and locked, req 2 valid → five consecutive grants to 1 (starting grant plus four), then grant 2; lock_active is 1 after grants 1 through 4 and 0 after grant 5.
- Enable gating: burst in progress (lcnt=2), enable=0 for 3 cycles → req_ready=0, q holds, q_update=0; enable=1 → grant returns to the locked requester and lcnt continues at 3.
- Mid-burst reset: lock_active=1, rst pulsed with req 3 valid → no write; q=0, ptr=0, and the first grant after reset goes by scan from index 0.
